// File: rtl/port_read_scheduler.sv
// Per-output-port dequeue scheduler: one descriptor FIFO per priority, with a single
// descriptor at a time handed to the read controller by strict priority or WRR.
module port_read_scheduler #(
  parameter int num_of_priority = 8,
  parameter int priority_width  = 3,
  parameter int queue_depth     = 8,
  parameter int address_width   = 12,
  parameter int length_width    = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sp0_wrr1,
  input  logic                       enq_vld,
  input  logic [priority_width-1:0]  enq_priority,
  input  logic [address_width-1:0]   enq_address,
  input  logic [length_width-1:0]    enq_length,
  output logic [num_of_priority-1:0] enq_full,
  output logic                       enq_overflow,
  input  logic                       rd_busy,
  output logic                       deq_vld,
  output logic [priority_width-1:0]  deq_priority,
  output logic [address_width-1:0]   deq_address,
  output logic [length_width-1:0]    deq_length,
  input  logic                       deq_ack
);

  localparam int cnt_width  = $clog2(queue_depth + 1);
  localparam int ptr_width  = (queue_depth > 1) ? $clog2(queue_depth) : 1;
  localparam int cred_width = $clog2(num_of_priority + 1);
  localparam int data_width = address_width + length_width;

  localparam logic [cnt_width-1:0]  cnt_zero  = {cnt_width{1'b0}};
  localparam logic [cnt_width-1:0]  cnt_one   = {{(cnt_width-1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0]  cnt_max   = cnt_width'(queue_depth);
  localparam logic [ptr_width-1:0]  ptr_zero  = {ptr_width{1'b0}};
  localparam logic [ptr_width-1:0]  ptr_one   = {{(ptr_width-1){1'b0}}, 1'b1};
  localparam logic [ptr_width-1:0]  ptr_last  = ptr_width'(queue_depth - 1);
  localparam logic [cred_width-1:0] cred_zero = {cred_width{1'b0}};
  localparam logic [cred_width-1:0] cred_one  = {{(cred_width-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                    state_r;
  logic [data_width-1:0]     mem_r    [num_of_priority][queue_depth];
  logic [cnt_width-1:0]      count_r  [num_of_priority];
  logic [ptr_width-1:0]      head_r   [num_of_priority];
  logic [ptr_width-1:0]      tail_r   [num_of_priority];
  logic [cred_width-1:0]     credit_r [num_of_priority];

  logic [num_of_priority-1:0] nonempty_s;
  logic [num_of_priority-1:0] full_s;
  logic [num_of_priority-1:0] eligible_s;
  logic [num_of_priority-1:0] push_hit_s;
  logic [num_of_priority-1:0] pop_hit_s;
  logic                       push_s;
  logic                       grant_s;
  logic                       any_eligible_s;
  logic [priority_width-1:0]  sel_sp_s;
  logic [priority_width-1:0]  sel_elig_s;
  logic [priority_width-1:0]  sel_s;
  logic [data_width-1:0]      head_data_s;

  // Per-queue status decoded from the count and credit registers.
  always_comb begin
    nonempty_s = {num_of_priority{1'b0}};
    full_s     = {num_of_priority{1'b0}};
    eligible_s = {num_of_priority{1'b0}};
    for (int p = 0; p < num_of_priority; p++) begin
      nonempty_s[p] = (count_r[p] != cnt_zero);
      full_s[p]     = (count_r[p] == cnt_max);
      eligible_s[p] = nonempty_s[p] && (credit_r[p] != cred_zero);
    end
  end

  // Grant selection; later loop iterations override, so the highest index wins.
  always_comb begin
    sel_sp_s   = {priority_width{1'b0}};
    sel_elig_s = {priority_width{1'b0}};
    for (int p = 0; p < num_of_priority; p++) begin
      sel_sp_s   = nonempty_s[p] ? priority_width'(p) : sel_sp_s;
      sel_elig_s = eligible_s[p] ? priority_width'(p) : sel_elig_s;
    end
    any_eligible_s = |eligible_s;
    if (sp0_wrr1 && any_eligible_s) begin
      sel_s = sel_elig_s;
    end else begin
      sel_s = sel_sp_s;
    end
    grant_s     = (state_r == IDLE) && !rd_busy && (|nonempty_s);
    head_data_s = mem_r[sel_s][head_r[sel_s]];
  end

  // Push/pop strobes per queue; full is the pre-edge value, so a pop never rescues a push.
  always_comb begin
    push_s     = enq_vld && !full_s[enq_priority];
    push_hit_s = {num_of_priority{1'b0}};
    pop_hit_s  = {num_of_priority{1'b0}};
    for (int p = 0; p < num_of_priority; p++) begin
      push_hit_s[p] = push_s && (enq_priority == priority_width'(p));
      pop_hit_s[p]  = grant_s && (sel_s == priority_width'(p));
    end
  end

  assign enq_full = full_s;

  // Descriptor storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[enq_priority][tail_r[enq_priority]] <= {enq_address, enq_length};
    end
  end

  // Queue pointers and occupancy counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < num_of_priority; p++) begin
        count_r[p] <= cnt_zero;
        head_r[p]  <= ptr_zero;
        tail_r[p]  <= ptr_zero;
      end
    end else begin
      for (int p = 0; p < num_of_priority; p++) begin
        if (push_hit_s[p]) begin
          tail_r[p] <= (tail_r[p] == ptr_last) ? ptr_zero : tail_r[p] + ptr_one;
        end
        if (pop_hit_s[p]) begin
          head_r[p] <= (head_r[p] == ptr_last) ? ptr_zero : head_r[p] + ptr_one;
        end
        case ({push_hit_s[p], pop_hit_s[p]})
          2'b10:   count_r[p] <= count_r[p] + cnt_one;
          2'b01:   count_r[p] <= count_r[p] - cnt_one;
          default: count_r[p] <= count_r[p];
        endcase
      end
    end
  end

  // Grant FSM with registered descriptor outputs, overflow pulse and WRR credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      deq_vld      <= 1'b0;
      deq_priority <= {priority_width{1'b0}};
      deq_address  <= {address_width{1'b0}};
      deq_length   <= {length_width{1'b0}};
      enq_overflow <= 1'b0;
      for (int p = 0; p < num_of_priority; p++) begin
        credit_r[p] <= cred_width'(p + 1);
      end
    end else begin
      enq_overflow <= enq_vld && full_s[enq_priority];
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            deq_vld                   <= 1'b1;
            deq_priority              <= sel_s;
            {deq_address, deq_length} <= head_data_s;
            state_r                   <= PRESENT;
            if (sp0_wrr1) begin
              if (any_eligible_s) begin
                credit_r[sel_s] <= credit_r[sel_s] - cred_one;
              end else begin
                // Round exhausted: reload every weight, charging this grant to the new round.
                for (int p = 0; p < num_of_priority; p++) begin
                  credit_r[p] <= (priority_width'(p) == sel_s) ? cred_width'(p)
                                                               : cred_width'(p + 1);
                end
              end
            end
          end else begin
            deq_vld <= 1'b0;
          end
        end
        PRESENT: begin
          if (deq_ack) begin
            deq_vld <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          deq_vld <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_read_scheduler.sv
// Directed bench for port_read_scheduler: expected descriptors are queued in grant
// order as stimulus is applied and compared as the scheduler presents them.
module tb_port_read_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp0_wrr1;
  logic        enq_vld;
  logic [2:0]  enq_priority;
  logic [11:0] enq_address;
  logic [6:0]  enq_length;
  logic [7:0]  enq_full;
  logic        enq_overflow;
  logic        rd_busy;
  logic        deq_vld;
  logic [2:0]  deq_priority;
  logic [11:0] deq_address;
  logic [6:0]  deq_length;
  logic        deq_ack;

  typedef struct packed {
    logic [2:0]  p;
    logic [11:0] a;
    logic [6:0]  l;
  } desc_t;

  desc_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;

  port_read_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sp0_wrr1     (sp0_wrr1),
    .enq_vld      (enq_vld),
    .enq_priority (enq_priority),
    .enq_address  (enq_address),
    .enq_length   (enq_length),
    .enq_full     (enq_full),
    .enq_overflow (enq_overflow),
    .rd_busy      (rd_busy),
    .deq_vld      (deq_vld),
    .deq_priority (deq_priority),
    .deq_address  (deq_address),
    .deq_length   (deq_length),
    .deq_ack      (deq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one enqueue across the next rising edge.
  task automatic enq(input logic [2:0] p, input logic [11:0] a, input logic [6:0] l,
                     input bit expect_out);
    desc_t d;
    enq_vld      = 1'b1;
    enq_priority = p;
    enq_address  = a;
    enq_length   = l;
    d.p = p; d.a = a; d.l = l;
    if (expect_out) exp_q.push_back(d);
    @(negedge clk);
    enq_vld = 1'b0;
  endtask

  // Waits (bounded) for a grant, checks it against the scoreboard, holds, then acks.
  task automatic take(input int hold, input string tag);
    desc_t e;
    int    n = 0;
    while (!deq_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " grant"}, deq_vld, 1);
    if (deq_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL %s unexpected descriptor observed=%0h expected=none", tag, deq_address);
      end else begin
        e = exp_q.pop_front();
        check({tag, " prio"}, deq_priority, e.p);
        check({tag, " addr"}, deq_address, e.a);
        check({tag, " len"}, deq_length, e.l);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check({tag, " hold vld"}, deq_vld, 1);
          check({tag, " hold addr"}, deq_address, e.a);
          check({tag, " hold len"}, deq_length, e.l);
        end
      end
      deq_ack = 1'b1;
      @(negedge clk);
      deq_ack = 1'b0;
      check({tag, " vld after ack"}, deq_vld, 0);
    end
  endtask

  task automatic expect_idle(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (deq_vld) seen++;
    end
    check({tag, " no grant"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; sp0_wrr1 = 1'b0; enq_vld = 1'b0; enq_priority = 3'd0;
    enq_address = 12'h000; enq_length = 7'd0; rd_busy = 1'b1; deq_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset deq_vld", deq_vld, 0);
    check("reset enq_full", enq_full, 8'h00);
    check("reset overflow", enq_overflow, 0);
    check("reset deq_addr", deq_address, 12'h000);
    rst = 1'b0;
    @(negedge clk);

    // Mid-run reset with a full queue and a descriptor on the output.
    for (int i = 0; i < 8; i++) enq(3'd6, 12'h600 + 12'(i), 7'd8, 1'b0);
    check("pre-rst full", enq_full, 8'h40);
    rd_busy = 1'b0;
    n = 0;
    while (!deq_vld && n < 20) begin @(negedge clk); n++; end
    check("pre-rst grant", deq_vld, 1);
    #2 rst = 1'b1;
    #1;
    check("rst deq_vld", deq_vld, 0);
    check("rst deq_prio", deq_priority, 3'd0);
    check("rst deq_addr", deq_address, 12'h000);
    check("rst deq_len", deq_length, 7'd0);
    check("rst enq_full", enq_full, 8'h00);
    check("rst overflow", enq_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_idle(5, "post-rst");

    // Strict priority ordering.
    rd_busy = 1'b1;
    sp0_wrr1 = 1'b0;
    enq(3'd2, 12'h010, 7'd3, 1'b0);
    enq(3'd5, 12'h020, 7'd4, 1'b0);
    enq(3'd7, 12'h030, 7'd5, 1'b0);
    exp_q.push_back('{3'd7, 12'h030, 7'd5});
    exp_q.push_back('{3'd5, 12'h020, 7'd4});
    exp_q.push_back('{3'd2, 12'h010, 7'd3});
    rd_busy = 1'b0;
    for (int i = 0; i < 3; i++) take(0, "sp");

    // WRR with weights 2 (prio1) and 1 (prio0): 1,1,0,1,1,0,0,0.
    rd_busy = 1'b1;
    sp0_wrr1 = 1'b1;
    for (int i = 0; i < 4; i++) enq(3'd1, 12'h100 + 12'(i), 7'd10 + 7'(i), 1'b0);
    for (int i = 0; i < 4; i++) enq(3'd0, 12'h200 + 12'(i), 7'd20 + 7'(i), 1'b0);
    exp_q.push_back('{3'd1, 12'h100, 7'd10});
    exp_q.push_back('{3'd1, 12'h101, 7'd11});
    exp_q.push_back('{3'd0, 12'h200, 7'd20});
    exp_q.push_back('{3'd1, 12'h102, 7'd12});
    exp_q.push_back('{3'd1, 12'h103, 7'd13});
    exp_q.push_back('{3'd0, 12'h201, 7'd21});
    exp_q.push_back('{3'd0, 12'h202, 7'd22});
    exp_q.push_back('{3'd0, 12'h203, 7'd23});
    rd_busy = 1'b0;
    for (int i = 0; i < 8; i++) take(0, "wrr");
    sp0_wrr1 = 1'b0;

    // Overflow: nine back-to-back enqueues into a depth-8 queue.
    rd_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      enq(3'd3, 12'h300 + 12'(i), 7'(i + 1), (i < 8));
      if (i == 6) check("ovf full after 7", enq_full[3], 0);
      if (i == 7) begin
        check("ovf full after 8", enq_full, 8'h08);
        check("ovf no pulse after 8", enq_overflow, 0);
      end
      if (i == 8) check("ovf pulse after 9", enq_overflow, 1);
    end
    @(negedge clk);
    check("ovf pulse ends", enq_overflow, 0);
    rd_busy = 1'b0;
    for (int i = 0; i < 8; i++) take(0, "ovf drain");
    expect_idle(5, "ovf");
    check("ovf full cleared", enq_full, 8'h00);

    // Latency and handshake stability.
    enq(3'd1, 12'h0AB, 7'd9, 1'b1);
    check("latency t", deq_vld, 0);
    enq(3'd1, 12'h0AC, 7'd11, 1'b1);
    check("latency t+1", deq_vld, 1);
    take(5, "hs");
    take(0, "hs2");

    // Enqueue to a full queue in the same cycle it is popped.
    rd_busy = 1'b1;
    for (int i = 0; i < 8; i++) enq(3'd4, 12'h400 + 12'(i), 7'd30 + 7'(i), 1'b1);
    check("conc full", enq_full, 8'h10);
    rd_busy = 1'b0;
    enq(3'd4, 12'h4FF, 7'd1, 1'b0);
    check("conc overflow", enq_overflow, 1);
    check("conc grant", deq_vld, 1);
    check("conc count7", enq_full, 8'h00);
    for (int i = 0; i < 8; i++) take(0, "conc drain");
    expect_idle(5, "conc");

    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
